// File: rtl/arduino_cmd_rx.sv
// 8N1 serial command receiver: samples the header rx pin, reassembles bytes and
// turns each good frame into a single-cycle game command pulse.
module arduino_cmd_rx #(
  parameter int CLKS_PER_BIT = 5208
) (
  input  logic       cin,
  input  logic       reset_n,
  input  logic       rx,
  output logic [7:0] rx_data,
  output logic       rx_valid,
  output logic       frame_err,
  output logic       busy,
  output logic       start_cmd,
  output logic       clear_cmd,
  output logic       p1_cmd,
  output logic       p2_cmd,
  output logic       unknown_cmd
);

  localparam int          HALF     = CLKS_PER_BIT / 2;
  localparam logic [15:0] CNT_HALF = 16'(HALF - 1);
  localparam logic [15:0] CNT_BIT  = 16'(CLKS_PER_BIT - 1);

  localparam logic [7:0] BYTE_START = 8'h53;
  localparam logic [7:0] BYTE_CLEAR = 8'h52;
  localparam logic [7:0] BYTE_P1    = 8'h31;
  localparam logic [7:0] BYTE_P2    = 8'h32;

  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_DATA,
    S_STOP,
    S_WAIT_HIGH
  } state_t;

  logic        r_sync1;
  logic        r_sync2;
  state_t      r_state;
  logic [15:0] r_cnt;
  logic [2:0]  r_bit_idx;
  logic [7:0]  r_shift;
  logic [7:0]  r_rx_data;
  logic        r_rx_valid;
  logic        r_frame_err;
  logic        r_start;
  logic        r_clear;
  logic        r_p1;
  logic        r_p2;
  logic        r_unknown;

  state_t      w_state_next;
  logic [15:0] w_cnt_next;
  logic [2:0]  w_bit_idx_next;
  logic [7:0]  w_shift_next;
  logic [7:0]  w_rx_data_next;
  logic        w_rx_valid_next;
  logic        w_frame_err_next;
  logic        w_start_next;
  logic        w_clear_next;
  logic        w_p1_next;
  logic        w_p2_next;
  logic        w_unknown_next;
  logic        w_rx_s;
  logic        w_bit_end;

  assign w_rx_s    = r_sync2;
  assign w_bit_end = (r_cnt == CNT_BIT);

  // rx is asynchronous to cin; nothing downstream looks at it before r_sync2
  always_ff @(posedge cin) begin
    if (!reset_n) begin
      r_sync1 <= 1'b1;
      r_sync2 <= 1'b1;
    end else begin
      r_sync1 <= rx;
      r_sync2 <= r_sync1;
    end
  end

  always_ff @(posedge cin) begin
    if (!reset_n) begin
      r_state     <= S_IDLE;
      r_cnt       <= 16'd0;
      r_bit_idx   <= 3'd0;
      r_shift     <= 8'h00;
      r_rx_data   <= 8'h00;
      r_rx_valid  <= 1'b0;
      r_frame_err <= 1'b0;
      r_start     <= 1'b0;
      r_clear     <= 1'b0;
      r_p1        <= 1'b0;
      r_p2        <= 1'b0;
      r_unknown   <= 1'b0;
    end else begin
      r_state     <= w_state_next;
      r_cnt       <= w_cnt_next;
      r_bit_idx   <= w_bit_idx_next;
      r_shift     <= w_shift_next;
      r_rx_data   <= w_rx_data_next;
      r_rx_valid  <= w_rx_valid_next;
      r_frame_err <= w_frame_err_next;
      r_start     <= w_start_next;
      r_clear     <= w_clear_next;
      r_p1        <= w_p1_next;
      r_p2        <= w_p2_next;
      r_unknown   <= w_unknown_next;
    end
  end

  always_comb begin
    w_state_next     = r_state;
    w_cnt_next       = r_cnt;
    w_bit_idx_next   = r_bit_idx;
    w_shift_next     = r_shift;
    w_rx_data_next   = r_rx_data;
    w_rx_valid_next  = 1'b0;
    w_frame_err_next = 1'b0;
    w_start_next     = 1'b0;
    w_clear_next     = 1'b0;
    w_p1_next        = 1'b0;
    w_p2_next        = 1'b0;
    w_unknown_next   = 1'b0;

    unique case (r_state)
      S_IDLE: begin
        if (!w_rx_s) begin
          w_state_next = S_START;
          w_cnt_next   = 16'd0;
        end
      end

      // Re-check the line at mid start bit so short glitches are dropped
      S_START: begin
        if (r_cnt != CNT_HALF) begin
          w_cnt_next = r_cnt + 16'd1;
        end else if (!w_rx_s) begin
          w_state_next   = S_DATA;
          w_cnt_next     = 16'd0;
          w_bit_idx_next = 3'd0;
        end else begin
          w_state_next = S_IDLE;
        end
      end

      S_DATA: begin
        if (!w_bit_end) begin
          w_cnt_next = r_cnt + 16'd1;
        end else begin
          w_shift_next   = {w_rx_s, r_shift[7:1]};
          w_bit_idx_next = r_bit_idx + 3'd1;
          w_cnt_next     = 16'd0;
          if (r_bit_idx == 3'd7) begin
            w_state_next = S_STOP;
          end
        end
      end

      // Leaving at mid stop bit leaves half a bit of slack for the next start edge
      S_STOP: begin
        if (!w_bit_end) begin
          w_cnt_next = r_cnt + 16'd1;
        end else begin
          w_cnt_next = 16'd0;
          if (w_rx_s) begin
            w_state_next    = S_IDLE;
            w_rx_data_next  = r_shift;
            w_rx_valid_next = 1'b1;
            unique case (r_shift)
              BYTE_START: w_start_next   = 1'b1;
              BYTE_CLEAR: w_clear_next   = 1'b1;
              BYTE_P1:    w_p1_next      = 1'b1;
              BYTE_P2:    w_p2_next      = 1'b1;
              default:    w_unknown_next = 1'b1;
            endcase
          end else begin
            w_state_next     = S_WAIT_HIGH;
            w_frame_err_next = 1'b1;
          end
        end
      end

      S_WAIT_HIGH: begin
        if (w_rx_s) begin
          w_state_next = S_IDLE;
        end
      end

      default: begin
        w_state_next = S_IDLE;
        w_cnt_next   = 16'd0;
      end
    endcase
  end

  assign rx_data     = r_rx_data;
  assign rx_valid    = r_rx_valid;
  assign frame_err   = r_frame_err;
  assign busy        = (r_state != S_IDLE);
  assign start_cmd   = r_start;
  assign clear_cmd   = r_clear;
  assign p1_cmd      = r_p1;
  assign p2_cmd      = r_p2;
  assign unknown_cmd = r_unknown;

endmodule

// File: tb/tb_arduino_cmd_rx.sv
// Scoreboard bench for arduino_cmd_rx: bit-exact 8N1 frames in, expected
// frame events queued by the driver and matched by an independent monitor.
module tb_arduino_cmd_rx;

  localparam int CPB = 16;
  // stop sample edge t0+2+H+9*CPB, t0 being one edge after the driving negedge
  localparam int LAT = 1 + 2 + CPB / 2 + 9 * CPB;

  logic       cin = 1'b0;
  logic       reset_n = 1'b0;
  logic       rx = 1'b1;
  logic [7:0] rx_data;
  logic       rx_valid, frame_err, busy;
  logic       start_cmd, clear_cmd, p1_cmd, p2_cmd, unknown_cmd;

  arduino_cmd_rx #(.CLKS_PER_BIT(CPB)) dut (
    .cin(cin), .reset_n(reset_n), .rx(rx),
    .rx_data(rx_data), .rx_valid(rx_valid), .frame_err(frame_err), .busy(busy),
    .start_cmd(start_cmd), .clear_cmd(clear_cmd), .p1_cmd(p1_cmd),
    .p2_cmd(p2_cmd), .unknown_cmd(unknown_cmd)
  );

  always #10 cin = ~cin;

  int cyc = 0;
  always @(posedge cin) cyc <= cyc + 1;

  typedef struct {
    bit         err;
    logic [7:0] data;
    logic [7:0] prev;
    int         cyc;
  } exp_t;

  exp_t       sb[$];
  int         n_vec = 0;
  int         n_miss = 0;
  logic [7:0] model_last = 8'h00;

  // {unknown, p2, p1, clear, start}
  function automatic logic [4:0] ref_decode(input logic [7:0] b);
    if (b == "S") return 5'b00001;
    if (b == "R") return 5'b00010;
    if (b == "1") return 5'b00100;
    if (b == "2") return 5'b01000;
    return 5'b10000;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    n_vec++;
    if (act !== req) begin
      n_miss++;
      $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, req, cyc);
    end
  endtask

  // Monitor: every pulse must match the oldest queued frame event
  always @(negedge cin) begin
    logic [4:0] w;
    exp_t e;
    w = {unknown_cmd, p2_cmd, p1_cmd, clear_cmd, start_cmd};
    if (reset_n && (rx_valid || frame_err || (w != 5'b0))) begin
      if (sb.size() == 0) begin
        check("unexpected_pulse", {25'b0, rx_valid, frame_err, w}, 32'h0);
      end else begin
        e = sb.pop_front();
        check("kind", {30'b0, rx_valid, frame_err}, e.err ? 32'h1 : 32'h2);
        check("decode", {27'b0, w}, e.err ? 32'h0 : {27'b0, ref_decode(e.data)});
        check("rx_data", {24'b0, rx_data}, {24'b0, e.err ? e.prev : e.data});
        check("latency", cyc, e.cyc);
        $display("frame data=%02h err=%0d at cycle %0d (expected %0d) rx_data=%02h pulses=%05b",
                 e.data, e.err, cyc, e.cyc, rx_data, w);
      end
    end
  end

  task automatic wait_cycles(input int n);
    repeat (n) @(negedge cin);
  endtask

  // Called right after a negedge; drives start, 8 data bits LSB first, stop
  task automatic send_frame(input logic [7:0] d, input bit stop_ok);
    exp_t e;
    e.err  = !stop_ok;
    e.data = d;
    e.prev = model_last;
    e.cyc  = cyc + LAT;
    sb.push_back(e);
    if (stop_ok) model_last = d;
    rx = 1'b0;
    wait_cycles(CPB);
    for (int k = 0; k < 8; k++) begin
      rx = d[k];
      wait_cycles(CPB);
    end
    rx = stop_ok;
    wait_cycles(CPB);
  endtask

  task automatic check_idle_outputs(input string name);
    check({name, "_rx_data"}, {24'b0, rx_data}, 32'h0);
    check({name, "_busy"}, {31'b0, busy}, 32'h0);
    check({name, "_pulses"},
          {25'b0, rx_valid, frame_err, unknown_cmd, p2_cmd, p1_cmd, clear_cmd, start_cmd}, 32'h0);
  endtask

  initial begin
    int cnt;
    logic [7:0] cmds[4];
    cmds[0] = 8'h53; cmds[1] = 8'h52; cmds[2] = 8'h31; cmds[3] = 8'h32;

    @(negedge cin);
    reset_n = 1'b0;
    wait_cycles(3);
    check_idle_outputs("reset");
    reset_n = 1'b1;
    wait_cycles(5);

    // Good 'S', back-to-back '1','2', unknown byte
    send_frame(8'h53, 1'b1);
    wait_cycles(10);
    send_frame(8'h31, 1'b1);
    send_frame(8'h32, 1'b1);
    wait_cycles(10);
    check("b2b_rx_data", {24'b0, rx_data}, 32'h32);
    send_frame(8'hA5, 1'b1);
    wait_cycles(10);

    // Framing error followed by a 100-cycle low hold
    send_frame(8'h52, 1'b0);
    cnt = 0;
    for (int i = 0; i < 100; i++) begin
      @(negedge cin);
      if (!busy) cnt++;
    end
    check("ferr_busy_held", cnt, 0);
    rx = 1'b1;
    wait_cycles(4);
    check("ferr_busy_release", {31'b0, busy}, 32'h0);
    check("ferr_rx_data_kept", {24'b0, rx_data}, 32'hA5);
    wait_cycles(200);

    // 4-cycle start glitch: busy for H cycles, no pulses
    rx = 1'b0;
    cnt = 0;
    for (int i = 0; i < 20; i++) begin
      @(negedge cin);
      if (i == 3) rx = 1'b1;
      if (busy) cnt++;
    end
    check("glitch_busy_cycles", cnt, CPB / 2);
    check("glitch_idle", {31'b0, busy}, 32'h0);
    wait_cycles(10);

    // Reset during data bit 3 of '1'
    rx = 1'b0;
    wait_cycles(CPB);
    for (int k = 0; k < 3; k++) begin
      rx = cmds[2][k];
      wait_cycles(CPB);
    end
    rx = cmds[2][3];
    wait_cycles(CPB / 2);
    reset_n = 1'b0;
    rx = 1'b1;
    model_last = 8'h00;
    @(negedge cin);
    reset_n = 1'b1;
    check_idle_outputs("midreset");
    wait_cycles(300);
    send_frame(8'h52, 1'b1);
    wait_cycles(10);
    check("after_reset_rx_data", {24'b0, rx_data}, 32'h52);

    // Randomized traffic
    for (int i = 0; i < 24; i++) begin
      logic [7:0] b;
      bit ok;
      b  = ($urandom_range(0, 2) == 0) ? 8'($urandom) : cmds[$urandom_range(0, 3)];
      ok = ($urandom_range(0, 5) != 0);
      send_frame(b, ok);
      if (!ok) begin
        wait_cycles($urandom_range(0, 40));
        rx = 1'b1;
        wait_cycles(4 + $urandom_range(0, 8));
      end else begin
        wait_cycles($urandom_range(0, 12));
      end
    end

    cnt = 0;
    while (sb.size() != 0 && cnt < 2000) begin
      @(negedge cin);
      cnt++;
    end
    check("scoreboard_drained", sb.size(), 0);
    wait_cycles(200);
    check("no_trailing_events", sb.size(), 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
